// File: rtl/csr_types.sv
// CSR layout types shared by the trap path: mip/mie/mcause layouts, privilege
// encoding, interrupt cause codes and the interrupt-request FSM encoding.
package csr_types;

  localparam int ECODE_W = 4;

  typedef enum logic [1:0] {
    USER_PRIVILEGE       = 2'b00,
    SUPERVISOR_PRIVILEGE = 2'b01,
    MACHINE_PRIVILEGE    = 2'b11
  } privilege_t;

  typedef struct packed {
    logic [15:0] custom;
    logic [3:0]  zero_15_12;
    logic        meip;
    logic        zero_10;
    logic        seip;
    logic        zero_8;
    logic        mtip;
    logic        zero_6;
    logic        stip;
    logic        zero_4;
    logic        msip;
    logic        zero_2;
    logic        ssip;
    logic        zero_0;
  } mip_t;

  typedef struct packed {
    logic [15:0] custom;
    logic [3:0]  zero_15_12;
    logic        meie;
    logic        zero_10;
    logic        seie;
    logic        zero_8;
    logic        mtie;
    logic        zero_6;
    logic        stie;
    logic        zero_4;
    logic        msie;
    logic        zero_2;
    logic        ssie;
    logic        zero_0;
  } mie_t;

  typedef struct packed {
    logic        is_interrupt;
    logic [30:0] code;
  } mcause_t;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_fsm_t;

  localparam logic [ECODE_W-1:0] M_EXT_INT   = 4'd11;
  localparam logic [ECODE_W-1:0] M_SOFT_INT  = 4'd3;
  localparam logic [ECODE_W-1:0] M_TIMER_INT = 4'd7;
  localparam logic [ECODE_W-1:0] S_EXT_INT   = 4'd9;
  localparam logic [ECODE_W-1:0] S_SOFT_INT  = 4'd1;
  localparam logic [ECODE_W-1:0] S_TIMER_INT = 4'd5;

  // Standard interrupt bit positions that can ever be eligible.
  localparam logic [11:0] IRQ_STD_MASK = 12'hAAA;

  // Code 0 is never a real interrupt cause, so it maps to an all-zero mcause;
  // this keeps the reset value of irq_mcause at zero.
  function automatic mcause_t irq_to_mcause(input logic [ECODE_W-1:0] code);
    mcause_t mc;
    mc = '0;
    if (code != '0) begin
      mc.is_interrupt = 1'b1;
      mc.code         = 31'(code);
    end
    return mc;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder over the 12 standard interrupt bits:
// MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5).
module irq_priority_encoder
  import csr_types::*;
(
  input  logic [11:0]        eligible,
  output logic               any,
  output logic [ECODE_W-1:0] code
);

  // Even positions hold no standard interrupt and never win arbitration.
  logic unused_even;
  assign unused_even = ^{eligible[10], eligible[8], eligible[6],
                         eligible[4], eligible[2], eligible[0]};

  // Pick the highest-priority pending cause.
  always_comb begin
    any  = 1'b1;
    code = '0;
    if (eligible[11])     code = M_EXT_INT;
    else if (eligible[3]) code = M_SOFT_INT;
    else if (eligible[7]) code = M_TIMER_INT;
    else if (eligible[9]) code = S_EXT_INT;
    else if (eligible[1]) code = S_SOFT_INT;
    else if (eligible[5]) code = S_TIMER_INT;
    else                  any  = 1'b0;
  end

endmodule

// File: rtl/interrupt_pending_unit.sv
// Machine interrupt-pending unit: holds mip, qualifies it against mie,
// mstatus.MIE and privilege, and issues one prioritized request with a
// valid/ack handshake followed by a re-arbitration holdoff.
// Optional macro IRQ_INPUT_SYNC_EN: 2-flop synchronizers on the four
// platform interrupt lines ahead of the mip register.
module interrupt_pending_unit
  import csr_types::*;
#(
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_software_irq,
  input  logic               m_timer_irq,
  input  logic               m_external_irq,
  input  logic               s_external_irq,
  input  logic [31:0]        mie,
  input  logic               mstatus_mie,
  input  logic [1:0]         privilege,
  input  logic               mip_we,
  input  logic [31:0]        mip_wdata,
  input  logic               commit_block,
  output logic [31:0]        mip,
  output logic               irq_valid,
  output logic [ECODE_W-1:0] irq_code,
  output logic [31:0]        irq_mcause,
  input  logic               irq_ack
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic msi_s, mti_s, mei_s, sei_s;

`ifdef IRQ_INPUT_SYNC_EN
  logic [3:0] sync_p0, sync_p1;

  // Two-flop synchronizer for the asynchronous platform lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {m_software_irq, m_timer_irq, m_external_irq, s_external_irq};
      sync_p1 <= sync_p0;
    end
  end

  assign {msi_s, mti_s, mei_s, sei_s} = sync_p1;
`else
  assign {msi_s, mti_s, mei_s, sei_s} =
    {m_software_irq, m_timer_irq, m_external_irq, s_external_irq};
`endif

  logic msip_q, mtip_q, meip_q, sei_q;
  logic ssip_q, stip_q, seip_sw_q;

  // mip state: hardware bits follow the lines, software bits follow CSR writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q    <= 1'b0;
      mtip_q    <= 1'b0;
      meip_q    <= 1'b0;
      sei_q     <= 1'b0;
      ssip_q    <= 1'b0;
      stip_q    <= 1'b0;
      seip_sw_q <= 1'b0;
    end else begin
      msip_q <= msi_s;
      mtip_q <= mti_s;
      meip_q <= mei_s;
      sei_q  <= sei_s;
      if (mip_we) begin
        ssip_q    <= mip_wdata[1];
        stip_q    <= mip_wdata[5];
        seip_sw_q <= mip_wdata[9];
      end
    end
  end

  mip_t mip_r;

  // Assemble the architectural mip view; custom and reserved fields read 0.
  always_comb begin
    mip_r      = '0;
    mip_r.msip = msip_q;
    mip_r.mtip = mtip_q;
    mip_r.meip = meip_q;
    mip_r.ssip = ssip_q;
    mip_r.stip = stip_q;
    mip_r.seip = seip_sw_q | sei_q;
  end

  assign mip = mip_r;

  logic unused_inputs;
  assign unused_inputs = ^{mie[31:12], mip_wdata[31:10], mip_wdata[8:6],
                           mip_wdata[4:2], mip_wdata[0]};

  logic        global_en;
  logic [11:0] eligible;
  logic [15:0] elig_ext;
  logic        enc_any;
  logic [ECODE_W-1:0] enc_code;

  assign global_en = (privilege != MACHINE_PRIVILEGE) | mstatus_mie;
  assign eligible  = mip[11:0] & mie[11:0] & IRQ_STD_MASK & {12{global_en}};
  assign elig_ext  = {4'b0, eligible};

  irq_priority_encoder u_enc (
    .eligible (eligible),
    .any      (enc_any),
    .code     (enc_code)
  );

  irq_fsm_t           state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ECODE_W-1:0] code_q;

  // Request handshake: arbitrate in IDLE, freeze in REQ, pause in HOLDOFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (enc_any && !commit_block) begin
            code_q  <= enc_code;
            state_q <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            if (HOLDOFF_CYCLES == 0) begin
              state_q <= IRQ_IDLE;
            end else begin
              state_q <= IRQ_HOLDOFF;
              cnt_q   <= CNT_W'(HOLDOFF_CYCLES);
            end
          end else if (!elig_ext[code_q]) begin
            state_q <= IRQ_IDLE;
          end
        end
        IRQ_HOLDOFF: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IRQ_IDLE;
      endcase
    end
  end

  assign irq_valid  = (state_q == IRQ_REQ);
  assign irq_code   = code_q;
  assign irq_mcause = irq_to_mcause(code_q);

endmodule
